// File: rtl/gpio_led_ctrl.sv
// GPIO command decoder and LED driver.
// Takes a toggle-strobed command word from CPU GPIO outputs and drives one LED as off, on,
// PWM-dimmed or blinking. Each accepted command toggles cmd_ack.

module gpio_led_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 78000000,
    parameter int unsigned PWM_PRESC   = 305
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic [14:0] gpio_cmd,
    output logic        led,
    output logic        cmd_ack,
    output logic [1:0]  mode_o
);

    localparam int unsigned TickDiv = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
    localparam int unsigned Presc   = (PWM_PRESC > 0) ? PWM_PRESC : 1;
    localparam int unsigned DivW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned PrescW  = (Presc > 1) ? $clog2(Presc) : 1;

    localparam logic [DivW-1:0]   DivLast   = DivW'(TickDiv - 1);
    localparam logic [PrescW-1:0] PrescLast = PrescW'(Presc - 1);

    typedef enum logic [2:0] {
        StOff,
        StOn,
        StPwm,
        StBlinkOn,
        StBlinkOff
    } state_e;

    logic [14:0]       cmd_s1_q, cmd_s2_q;
    logic              strobe_last_q;
    logic [1:0]        warm_q;
    state_e            state_q;
    logic [1:0]        mode_q;
    logic [11:0]       value_q;
    logic              led_q;
    logic              ack_q;
    logic [PrescW-1:0] presc_q;
    logic [7:0]        phase_q;
    logic [DivW-1:0]   div_q;
    logic [11:0]       half_q;

    logic        accept;
    logic [1:0]  new_mode;
    logic [11:0] new_value;
    logic [7:0]  phase_nxt;
    logic        half_done;

    // value[8:0] saturated at 256
    function automatic logic [8:0] duty_of(input logic [11:0] v);
        return v[8] ? 9'd256 : {1'b0, v[7:0]};
    endfunction

    // Half-period in ms, zero treated as one
    function automatic logic [11:0] half_of(input logic [11:0] v);
        return (v == 12'd0) ? 12'd1 : v;
    endfunction

    // Accept is held off until the sync chain and last flop carry post-reset samples, so a
    // strobe line sitting high across reset does not replay a stale command.
    assign accept    = (warm_q == 2'd3) && (cmd_s2_q[14] != strobe_last_q);
    assign new_mode  = cmd_s2_q[13:12];
    assign new_value = cmd_s2_q[11:0];
    assign phase_nxt = phase_q + 8'd1;
    assign half_done = ({1'b0, half_q} + 13'd1) >= {1'b0, half_of(value_q)};

    // Two-flop sync of the whole command word plus the strobe history flop
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_s1_q      <= '0;
            cmd_s2_q      <= '0;
            strobe_last_q <= 1'b0;
            warm_q        <= 2'd0;
        end else begin
            cmd_s1_q      <= gpio_cmd;
            cmd_s2_q      <= cmd_s1_q;
            strobe_last_q <= cmd_s2_q[14];
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    // Mode FSM with registered LED, ack and counters; accept overrides any counter step
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StOff;
            mode_q  <= 2'b00;
            value_q <= '0;
            led_q   <= 1'b0;
            ack_q   <= 1'b0;
            presc_q <= '0;
            phase_q <= '0;
            div_q   <= '0;
            half_q  <= '0;
        end else if (accept) begin
            ack_q   <= ~ack_q;
            mode_q  <= new_mode;
            value_q <= new_value;
            presc_q <= '0;
            phase_q <= '0;
            div_q   <= '0;
            half_q  <= '0;
            unique case (new_mode)
                2'b00: begin
                    state_q <= StOff;
                    led_q   <= 1'b0;
                end
                2'b01: begin
                    state_q <= StOn;
                    led_q   <= 1'b1;
                end
                2'b10: begin
                    state_q <= StPwm;
                    led_q   <= (duty_of(new_value) != 9'd0);
                end
                default: begin
                    state_q <= StBlinkOn;
                    led_q   <= 1'b1;
                end
            endcase
        end else begin
            unique case (state_q)
                StPwm: begin
                    if (presc_q == PrescLast) begin
                        presc_q <= '0;
                        phase_q <= phase_nxt;
                        led_q   <= ({1'b0, phase_nxt} < duty_of(value_q));
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                StBlinkOn, StBlinkOff: begin
                    if (div_q == DivLast) begin
                        div_q <= '0;
                        if (half_done) begin
                            half_q  <= '0;
                            state_q <= (state_q == StBlinkOn) ? StBlinkOff : StBlinkOn;
                            led_q   <= (state_q == StBlinkOff);
                        end else begin
                            half_q <= half_q + 12'd1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign led     = led_q;
    assign cmd_ack = ack_q;
    assign mode_o  = mode_q;

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Randomized bench for gpio_led_ctrl against a time-based reference model: the expected LED
// is computed directly from the cycles elapsed since the last accepted command.

module tb_gpio_led_ctrl;

    localparam int unsigned ClkHz = 1000;
    localparam int unsigned Presc = 1;
    localparam int unsigned Tick  = ClkHz / 1000;

    logic        sys_clk;
    logic        reset_n;
    logic [14:0] gpio_cmd;
    logic        led;
    logic        cmd_ack;
    logic [1:0]  mode_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          check_en = 1'b0;

    // Reference model state
    int          cyc = 0;
    logic [14:0] h0 = '0, h1 = '0, h2 = '0;
    logic        m_last = 1'b0;
    logic [1:0]  m_mode = 2'b00;
    logic [11:0] m_value = '0;
    logic        m_ack = 1'b0;
    int          m_acc = 0;

    gpio_led_ctrl #(
        .CLK_FREQ_HZ(ClkHz),
        .PWM_PRESC  (Presc)
    ) u_dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .gpio_cmd(gpio_cmd),
        .led     (led),
        .cmd_ack (cmd_ack),
        .mode_o  (mode_o)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // A strobe level first seen at edge t-2 differing from the last accepted level is a command
    always @(posedge sys_clk) begin
        cyc++;
        h2 = h1;
        h1 = h0;
        h0 = gpio_cmd;
        if (!reset_n) begin
            m_mode  = 2'b00;
            m_value = '0;
            m_ack   = 1'b0;
            m_last  = gpio_cmd[14];
            m_acc   = cyc;
        end else if (cyc >= 3 && h2[14] != m_last) begin
            m_last  = h2[14];
            m_mode  = h2[13:12];
            m_value = h2[11:0];
            m_ack   = ~m_ack;
            m_acc   = cyc;
        end
    end

    function automatic int exp_led();
        int e;
        int phase;
        int duty;
        int h;
        e = cyc - m_acc;
        case (m_mode)
            2'b00: return 0;
            2'b01: return 1;
            2'b10: begin
                phase = (e / Presc) % 256;
                duty  = m_value[8] ? 256 : int'(m_value[7:0]);
                return (phase < duty) ? 1 : 0;
            end
            default: begin
                h = (m_value == 12'd0) ? 1 : int'(m_value);
                return (((e / Tick) / h) % 2 == 0) ? 1 : 0;
            end
        endcase
    endfunction

    always @(negedge sys_clk) begin
        if (reset_n && check_en) begin
            check_eq("led", int'(led), exp_led());
            check_eq("ack", int'(cmd_ack), int'(m_ack));
            check_eq("mode", int'(mode_o), int'(m_mode));
        end
    end

    task automatic send(input logic [1:0] m, input logic [11:0] v, input int hold);
        gpio_cmd = {~gpio_cmd[14], m, v};
        repeat (hold) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] m, input logic [11:0] v, input int hold);
        gpio_cmd[13:0] = {m, v};
        repeat (hold) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [1:0]  rm;
        logic [11:0] rv;
        int          rh;

        reset_n  = 1'b0;
        gpio_cmd = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_led", int'(led), 0);
        check_eq("rst_ack", int'(cmd_ack), 0);
        check_eq("rst_mode", int'(mode_o), 0);
        reset_n  = 1'b1;
        check_en = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1;

        // On/off and accept latency
        send(2'b01, 12'd0, 10);
        send(2'b00, 12'd0, 10);

        // PWM duties, including both saturation ends
        send(2'b10, 12'd64, 600);
        send(2'b10, 12'd0, 1100);
        send(2'b10, 12'h100, 600);
        send(2'b10, 12'h1ff, 300);
        send(2'b10, 12'h0c3, 300);

        // Blink, then the zero half-period case
        send(2'b11, 12'd5, 40);
        send(2'b11, 12'd0, 20);

        // Identical blink re-sent while the LED is in its off half
        send(2'b11, 12'd5, 8);
        send(2'b11, 12'd5, 30);

        // Field change without a strobe toggle
        send(2'b01, 12'd0, 10);
        set_fields(2'b10, 12'h040, 100);

        // Random command mix with occasional field-only changes
        for (int i = 0; i < 40; i++) begin
            rm = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 12))
                                             : 12'($urandom_range(0, 4095));
            rh = int'($urandom_range(4, 300));
            if ($urandom_range(0, 4) == 0) begin
                set_fields(rm, rv, rh);
            end else begin
                send(rm, rv, rh);
            end
        end

        // Asynchronous reset mid-blink
        send(2'b11, 12'd7, 20);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_led", int'(led), 0);
        check_eq("async_ack", int'(cmd_ack), 0);
        check_eq("async_mode", int'(mode_o), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        repeat (30) @(posedge sys_clk);
        #1;
        send(2'b01, 12'd0, 10);
        send(2'b11, 12'd3, 20);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
